rc4_keystream_xor: RTL and testbench

Downstream stage of the RC4 core. Consumes PRGA keystream bytes over a valid/ready port, buffers them in a small FIFO so the PRGA can run ahead, and XORs each with one plaintext (or ciphertext) byte to produce an output byte stream. Accepts exactly `msg_len` keystream bytes per message, so no keystream byte is lost or consumed early. Signals completion with a one-cycle `done`.

---
 rtl/rc4_pkg.sv | 12 +
 rtl/rc4_byte_fifo.sv | 45 ++++
 rtl/rc4_keystream_xor.sv | 119 +++++++++++
 tb/tb_rc4_keystream_xor.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rc4_pkg.sv
// Shared types and widths for the RC4 datapath stages.
package rc4_pkg;

  localparam int unsigned BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } xor_state_t;

endpackage

// File: rtl/rc4_byte_fifo.sv
// Small byte FIFO buffering PRGA keystream ahead of the XOR stage.
module rc4_byte_fifo
  import rc4_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              push,
  input  logic [BYTE_W-1:0] push_data,
  input  logic              pop,
  output logic [BYTE_W-1:0] head_data,
  output logic              full,
  output logic              empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [BYTE_W-1:0] mem [DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;

  // Extra pointer bit distinguishes full from empty when the indices match.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

  assign head_data = mem[rd_ptr[AW-1:0]];
  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_ptr[AW] != rd_ptr[AW]) &&
                     (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/rc4_keystream_xor.sv
// XORs buffered RC4 keystream bytes with a data stream, exactly msg_len bytes
// per message, and pulses done at the end.
module rc4_keystream_xor
  import rc4_pkg::*;
#(
  parameter int unsigned KS_DEPTH = 4,
  parameter int unsigned LEN_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [LEN_W-1:0]  msg_len,
  input  logic              ks_valid,
  input  logic [BYTE_W-1:0] ks_data,
  output logic              ks_ready,
  input  logic              din_valid,
  input  logic [BYTE_W-1:0] din_data,
  output logic              din_ready,
  output logic              dout_valid,
  output logic [BYTE_W-1:0] dout_data,
  input  logic              dout_ready,
  output logic              busy,
  output logic              done,
  output logic [LEN_W-1:0]  byte_cnt
);

  xor_state_t        state_q;
  xor_state_t        state_next;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  ks_cnt;
  logic              start_accept;
  logic              fifo_full;
  logic              fifo_empty;
  logic [BYTE_W-1:0] fifo_head;
  logic              ks_hs;
  logic              din_hs;
  logic              dout_hs;

  assign ks_hs   = ks_valid && ks_ready;
  assign din_hs  = din_valid && din_ready;
  assign dout_hs = dout_valid && dout_ready;

  rc4_byte_fifo #(
    .DEPTH (KS_DEPTH)
  ) u_ks_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (start_accept),
    .push      (ks_hs),
    .push_data (ks_data),
    .pop       (din_hs),
    .head_data (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_next;
  end

  // Readies depend only on registered state and dout_ready.
  always_comb begin
    state_next   = state_q;
    start_accept = 1'b0;
    ks_ready     = 1'b0;
    din_ready    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (msg_len != '0) begin
            start_accept = 1'b1;
            state_next   = RUN;
          end else begin
            state_next   = DONE;
          end
        end
      end
      RUN: begin
        ks_ready  = !fifo_full && (ks_cnt < len_q);
        din_ready = !fifo_empty && (!dout_valid || dout_ready);
        if (dout_hs && (byte_cnt == len_q - LEN_W'(1))) state_next = DONE;
      end
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      len_q      <= '0;
      ks_cnt     <= '0;
      byte_cnt   <= '0;
      dout_valid <= 1'b0;
      dout_data  <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      busy <= (state_next == RUN);
      done <= (state_next == DONE);
      if (start_accept) begin
        len_q    <= msg_len;
        ks_cnt   <= '0;
        byte_cnt <= '0;
      end else begin
        if (ks_hs)   ks_cnt   <= ks_cnt + LEN_W'(1);
        if (dout_hs) byte_cnt <= byte_cnt + LEN_W'(1);
      end
      // Output register holds while stalled; a pop refills it in the same cycle it drains.
      if (din_hs) begin
        dout_data  <= din_data ^ fifo_head;
        dout_valid <= 1'b1;
      end else if (dout_hs) begin
        dout_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rc4_keystream_xor.sv
// Directed bench for rc4_keystream_xor with hand-computed XOR results.
module tb_rc4_keystream_xor;

  localparam int unsigned KS_DEPTH = 4;
  localparam int unsigned LEN_W    = 16;

  logic             clk;
  logic             rst;
  logic             start;
  logic [LEN_W-1:0] msg_len;
  logic             ks_valid;
  logic [7:0]       ks_data;
  logic             ks_ready;
  logic             din_valid;
  logic [7:0]       din_data;
  logic             din_ready;
  logic             dout_valid;
  logic [7:0]       dout_data;
  logic             dout_ready;
  logic             busy;
  logic             done;
  logic [LEN_W-1:0] byte_cnt;

  rc4_keystream_xor #(
    .KS_DEPTH (KS_DEPTH),
    .LEN_W    (LEN_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .msg_len    (msg_len),
    .ks_valid   (ks_valid),
    .ks_data    (ks_data),
    .ks_ready   (ks_ready),
    .din_valid  (din_valid),
    .din_data   (din_data),
    .din_ready  (din_ready),
    .dout_valid (dout_valid),
    .dout_data  (dout_data),
    .dout_ready (dout_ready),
    .busy       (busy),
    .done       (done),
    .byte_cnt   (byte_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors;
  int miscompares;

  logic [7:0] ks_src  [32];
  logic [7:0] din_src [32];
  logic [7:0] out_buf [32];
  int ks_i, din_i, ks_avail, din_avail;
  int n_out, ks_hs_n, din_hs_n, done_cnt, done_cycle, first_dout, last_dout, max_bc;
  logic busy_seen, busy_c0, busy_pre, last_ksr;
  logic stall_changed, din_rdy_stall, stall_have, ksr_end;
  logic [7:0] stall_val;
  int occ_end;

  task automatic clear_log();
    n_out = 0; ks_hs_n = 0; din_hs_n = 0; done_cnt = 0; done_cycle = -1;
    first_dout = -1; last_dout = -1; max_bc = 0; busy_seen = 1'b0; busy_c0 = 1'b0;
    stall_changed = 1'b0; din_rdy_stall = 1'b0; stall_have = 1'b0; stall_val = 8'h00;
    ksr_end = 1'b1; occ_end = -1; last_ksr = 1'b0;
  endtask

  task automatic new_sources(input int nks, input int ndin);
    ks_i = 0; din_i = 0; ks_avail = nks; din_avail = ndin;
  endtask

  task automatic do_start(input logic [LEN_W-1:0] len);
    @(negedge clk);
    start = 1'b1;
    msg_len = len;
    #1 busy_pre = busy;
  endtask

  // Plays source/sink for a fixed number of cycles and logs what it observes.
  task automatic run(input int cycles, input int stall_from, input int stall_to,
                     input int st_cycle, input logic [LEN_W-1:0] st_len);
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      start = (c == st_cycle);
      if (c == st_cycle) msg_len = st_len;
      ks_valid   = (ks_i < ks_avail);
      ks_data    = (ks_i < 32) ? ks_src[ks_i] : 8'h00;
      din_valid  = (din_i < din_avail);
      din_data   = (din_i < 32) ? din_src[din_i] : 8'h00;
      dout_ready = !(c >= stall_from && c < stall_to);
      #1;
      if (busy) busy_seen = 1'b1;
      if (c == 0) busy_c0 = busy;
      if (done) begin done_cnt++; done_cycle = c; end
      if (int'(byte_cnt) > max_bc) max_bc = int'(byte_cnt);
      last_ksr = ks_ready;
      if (!dout_ready) begin
        if (dout_valid && stall_have && dout_data !== stall_val) stall_changed = 1'b1;
        stall_val  = dout_data;
        stall_have = dout_valid;
        if (din_ready) din_rdy_stall = 1'b1;
        occ_end = ks_i - din_i;
        ksr_end = ks_ready;
      end
      if (ks_valid && ks_ready) begin ks_i++; ks_hs_n++; end
      if (din_valid && din_ready) begin din_i++; din_hs_n++; end
      if (dout_valid && dout_ready) begin
        if (n_out < 32) out_buf[n_out] = dout_data;
        n_out++;
        if (first_dout < 0) first_dout = c;
        last_dout = c;
      end
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; msg_len = '0;
    ks_valid = 1'b1; ks_data = 8'h12; din_valid = 1'b1; din_data = 8'h34; dout_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    vectors++;
    if ({ks_ready, din_ready, dout_valid, busy, done} !== 5'b0 || dout_data !== 8'h00 ||
        byte_cnt !== 16'h0) begin
      miscompares++;
      $display("FAIL reset_outputs got rdy=%b/%b dv=%b busy=%b done=%b dd=%h bc=%0d exp all 0",
               ks_ready, din_ready, dout_valid, busy, done, dout_data, byte_cnt);
    end
    rst = 1'b0;
  endtask

  task automatic test_basic_xor();
    logic [7:0] exp_b [3];
    exp_b = '{8'hAB, 8'h57, 8'h0C};
    ks_src[0] = 8'hAA; ks_src[1] = 8'h55; ks_src[2] = 8'h0F;
    din_src[0] = 8'h01; din_src[1] = 8'h02; din_src[2] = 8'h03;
    new_sources(3, 3); clear_log();
    do_start(16'd3);
    run(10, -1, -1, -1, '0);
    vectors++;
    if (n_out !== 3) begin miscompares++; $display("FAIL basic_count got %0d exp 3", n_out); end
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (out_buf[i] !== exp_b[i]) begin
        miscompares++; $display("FAIL basic_byte%0d got %h exp %h", i, out_buf[i], exp_b[i]);
      end
    end
    vectors++;
    if (first_dout !== 2) begin miscompares++; $display("FAIL basic_first_dout got %0d exp 2", first_dout); end
    vectors++;
    if (done_cnt !== 1 || done_cycle !== last_dout + 1) begin
      miscompares++; $display("FAIL basic_done got cnt=%0d cyc=%0d exp cnt=1 cyc=%0d", done_cnt, done_cycle, last_dout + 1);
    end
    vectors++;
    if (max_bc !== 3) begin miscompares++; $display("FAIL basic_byte_cnt got %0d exp 3", max_bc); end
    vectors++;
    if (busy_pre !== 1'b0 || busy_c0 !== 1'b1) begin
      miscompares++; $display("FAIL basic_busy_rise got pre=%b c0=%b exp 0 1", busy_pre, busy_c0);
    end
  endtask

  task automatic test_ks_limit();
    for (int i = 0; i < 10; i++) ks_src[i] = 8'h5A + 8'(i);
    din_src[0] = 8'h0F; din_src[1] = 8'hF0;
    new_sources(10, 0); clear_log();
    do_start(16'd2);
    run(10, -1, -1, -1, '0);
    vectors++;
    if (ks_hs_n !== 2) begin miscompares++; $display("FAIL ks_limit_hs got %0d exp 2", ks_hs_n); end
    vectors++;
    if (last_ksr !== 1'b0) begin miscompares++; $display("FAIL ks_limit_ready got %b exp 0", last_ksr); end
    din_avail = 2; clear_log();
    run(8, -1, -1, -1, '0);
    vectors++;
    if (ks_hs_n !== 0 || n_out !== 2 || out_buf[0] !== 8'h55 || out_buf[1] !== 8'hAB) begin
      miscompares++;
      $display("FAIL ks_limit_out got hs=%0d n=%0d %h %h exp 0 2 55 ab", ks_hs_n, n_out, out_buf[0], out_buf[1]);
    end
    vectors++;
    if (done_cnt !== 1) begin miscompares++; $display("FAIL ks_limit_done got %0d exp 1", done_cnt); end
  endtask

  task automatic test_backpressure();
    logic [7:0] exp_b [8];
    exp_b = '{8'hF0, 8'hE0, 8'hD0, 8'hC0, 8'hB0, 8'hA0, 8'h90, 8'h80};
    for (int i = 0; i < 8; i++) begin
      ks_src[i]  = 8'h11 * 8'(i);
      din_src[i] = 8'hF0 + 8'(i);
    end
    new_sources(8, 8); clear_log();
    do_start(16'd8);
    run(40, 4, 10, -1, '0);
    vectors++;
    if (stall_changed !== 1'b0 || stall_have !== 1'b1) begin
      miscompares++; $display("FAIL bp_stable got changed=%b held=%b exp 0 1", stall_changed, stall_have);
    end
    vectors++;
    if (din_rdy_stall !== 1'b0) begin miscompares++; $display("FAIL bp_din_ready got %b exp 0", din_rdy_stall); end
    vectors++;
    if (occ_end !== int'(KS_DEPTH) || ksr_end !== 1'b0) begin
      miscompares++; $display("FAIL bp_fifo_full got occ=%0d ksr=%b exp %0d 0", occ_end, ksr_end, KS_DEPTH);
    end
    vectors++;
    if (n_out !== 8) begin miscompares++; $display("FAIL bp_count got %0d exp 8", n_out); end
    for (int i = 0; i < 8; i++) begin
      vectors++;
      if (out_buf[i] !== exp_b[i]) begin
        miscompares++; $display("FAIL bp_byte%0d got %h exp %h", i, out_buf[i], exp_b[i]);
      end
    end
    vectors++;
    if (done_cnt !== 1) begin miscompares++; $display("FAIL bp_done got %0d exp 1", done_cnt); end
  endtask

  task automatic test_zero_len();
    ks_src[0] = 8'h77; din_src[0] = 8'h66;
    new_sources(1, 1); clear_log();
    do_start(16'd0);
    run(5, -1, -1, -1, '0);
    vectors++;
    if (done_cnt !== 1 || done_cycle !== 0) begin
      miscompares++; $display("FAIL zero_done got cnt=%0d cyc=%0d exp 1 0", done_cnt, done_cycle);
    end
    vectors++;
    if (ks_hs_n !== 0 || din_hs_n !== 0 || n_out !== 0) begin
      miscompares++; $display("FAIL zero_hs got ks=%0d din=%0d dout=%0d exp 0 0 0", ks_hs_n, din_hs_n, n_out);
    end
    vectors++;
    if (busy_seen !== 1'b0) begin miscompares++; $display("FAIL zero_busy got %b exp 0", busy_seen); end
  endtask

  task automatic test_mid_reset();
    for (int i = 0; i < 5; i++) begin
      ks_src[i] = 8'hC0 + 8'(i); din_src[i] = 8'h0C;
    end
    new_sources(5, 5); clear_log();
    do_start(16'd5);
    run(4, -1, -1, -1, '0);
    vectors++;
    if (n_out !== 2) begin miscompares++; $display("FAIL mrst_pre_count got %0d exp 2", n_out); end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #1;
    vectors++;
    if ({ks_ready, din_ready, dout_valid, busy, done} !== 5'b0 || dout_data !== 8'h00 ||
        byte_cnt !== 16'h0) begin
      miscompares++;
      $display("FAIL mrst_outputs got rdy=%b/%b dv=%b busy=%b done=%b dd=%h bc=%0d exp all 0",
               ks_ready, din_ready, dout_valid, busy, done, dout_data, byte_cnt);
    end
    rst = 1'b0;
    ks_src[0] = 8'h10; ks_src[1] = 8'h20; din_src[0] = 8'h01; din_src[1] = 8'h01;
    new_sources(2, 2); clear_log();
    do_start(16'd2);
    run(10, -1, -1, -1, '0);
    vectors++;
    if (n_out !== 2 || out_buf[0] !== 8'h11 || out_buf[1] !== 8'h21) begin
      miscompares++; $display("FAIL mrst_restart got n=%0d %h %h exp 2 11 21", n_out, out_buf[0], out_buf[1]);
    end
    vectors++;
    if (done_cnt !== 1) begin miscompares++; $display("FAIL mrst_done got %0d exp 1", done_cnt); end
  endtask

  task automatic test_start_in_run();
    for (int i = 0; i < 7; i++) ks_src[i] = 8'h01 + 8'(i);
    for (int i = 0; i < 7; i++) din_src[i] = 8'h00;
    new_sources(7, 7); clear_log();
    do_start(16'd3);
    run(15, -1, -1, 1, 16'd7);
    vectors++;
    if (ks_hs_n !== 3 || n_out !== 3) begin
      miscompares++; $display("FAIL sir_len got ks=%0d out=%0d exp 3 3", ks_hs_n, n_out);
    end
    vectors++;
    if (out_buf[2] !== 8'h03 || max_bc !== 3) begin
      miscompares++; $display("FAIL sir_data got %h bc=%0d exp 03 3", out_buf[2], max_bc);
    end
    vectors++;
    if (done_cnt !== 1) begin miscompares++; $display("FAIL sir_done got %0d exp 1", done_cnt); end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_basic_xor();
    test_ks_limit();
    test_backpressure();
    test_zero_len();
    test_mid_reset();
    test_start_in_run();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
